// File: rtl/shift_reg_sequencer_if.sv
`timescale 1ns/1ps
// shift_reg_sequencer_if
// Bundles the command side and the register side of the shift-register
// sequencer so the sequencer and its environment share one port list.
//
// Handshake: start is a one-cycle request with no ready. The sequencer accepts
// it only while idle (busy=0, done=0); a request at any other time is dropped,
// never queued. A command ends with a one-cycle done pulse (err alongside it
// for an illegal cmd), or silently if abort is taken while busy.
//
// Signals
//   start, cmd[2:0], count[3:0], data_in[3:0], si_in, abort : command side
//   q[3:0]                     : current register contents (rotate feedback)
//   M[1:0], SI, D[3:0], step_en : register controls
//   busy, done, err            : status
//
// Modports: master = command source / register, slave = the sequencer.
interface shift_reg_sequencer_if;
  logic       start;
  logic [2:0] cmd;
  logic [3:0] count;
  logic [3:0] data_in;
  logic       si_in;
  logic       abort;
  logic [3:0] q;
  logic [1:0] M;
  logic       SI;
  logic [3:0] D;
  logic       step_en;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, cmd, count, data_in, si_in, abort, q,
    input  M, SI, D, step_en, busy, done, err
  );

  modport slave (
    input  start, cmd, count, data_in, si_in, abort, q,
    output M, SI, D, step_en, busy, done, err
  );
endinterface

// File: rtl/shift_reg_sequencer.sv
`timescale 1ns/1ps
// shift_reg_sequencer
// Turns one command (LOAD, CLEAR, SHR, SHL, ROR, ROL with a step count) into
// a paced series of single-cycle step enables for a 4-bit universal shift
// register, driving its mode (M), serial input (SI) and parallel data (D).
// Consecutive steps are STEP_GAP cycles apart (legal range 1..15).
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   bus        : shift_reg_sequencer_if.slave (command, status, register side)
//   state_dbg  : current FSM state (0 IDLE, 1 STEP, 2 GAP, 3 DONE)
module shift_reg_sequencer #(
  parameter int unsigned STEP_GAP = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  shift_reg_sequencer_if.slave        bus,
  output logic [1:0]                  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] CMD_LOAD  = 3'b000;
  localparam logic [2:0] CMD_CLEAR = 3'b001;
  localparam logic [2:0] CMD_SHR   = 3'b010;
  localparam logic [2:0] CMD_SHL   = 3'b011;
  localparam logic [2:0] CMD_ROR   = 3'b100;
  localparam logic [2:0] CMD_ROL   = 3'b101;

  // GAP lasts STEP_GAP-1 cycles; the counter counts down to zero, so it is
  // loaded with STEP_GAP-2. Unused when STEP_GAP=1 (GAP is never entered).
  localparam logic [3:0] GAP_RELOAD = (STEP_GAP > 1) ? 4'(STEP_GAP - 2) : 4'd0;

  function automatic logic [1:0] mode_of(input logic [2:0] c);
    logic [1:0] m;
    case (c)
      CMD_LOAD, CMD_CLEAR: m = 2'b11;
      CMD_SHR, CMD_ROR:    m = 2'b01;
      CMD_SHL, CMD_ROL:    m = 2'b10;
      default:             m = 2'b00;
    endcase
    return m;
  endfunction

  state_t     state;
  logic [2:0] cmd_r;
  logic       si_r;
  logic [3:0] rem;
  logic [3:0] gap_cnt;
  logic [1:0] m_r;
  logic [3:0] d_r;
  logic       step_r;
  logic       busy_r;
  logic       done_r;
  logic       err_r;
  logic       si_c;

  logic illegal;
  logic single_step;

  assign illegal     = bus.cmd[2] & bus.cmd[1];
  assign single_step = (bus.cmd[2:1] == 2'b00);  // LOAD or CLEAR

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cmd_r   <= 3'b000;
      si_r    <= 1'b0;
      rem     <= 4'd0;
      gap_cnt <= 4'd0;
      m_r     <= 2'b00;
      d_r     <= 4'd0;
      step_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cmd_r <= bus.cmd;
            si_r  <= bus.si_in;
            d_r   <= (bus.cmd == CMD_CLEAR) ? 4'd0 : bus.data_in;
            if (illegal) begin
              state  <= DONE;
              done_r <= 1'b1;
              err_r  <= 1'b1;
            end else if (!single_step && bus.count == 4'd0) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state  <= STEP;
              step_r <= 1'b1;
              busy_r <= 1'b1;
              m_r    <= mode_of(bus.cmd);
              rem    <= single_step ? 4'd1 : bus.count;
            end
          end
        end

        STEP: begin
          if (bus.abort) begin
            state  <= IDLE;
            step_r <= 1'b0;
            busy_r <= 1'b0;
            m_r    <= 2'b00;
          end else begin
            // rem counts the step happening now; saturate rather than wrap.
            rem <= (rem == 4'd0) ? 4'd0 : rem - 4'd1;
            if (rem <= 4'd1) begin
              state  <= DONE;
              step_r <= 1'b0;
              busy_r <= 1'b0;
              m_r    <= 2'b00;
              done_r <= 1'b1;
            end else if (STEP_GAP == 1) begin
              // Back-to-back steps: stay in STEP with outputs unchanged.
              state <= STEP;
            end else begin
              state   <= GAP;
              step_r  <= 1'b0;
              m_r     <= 2'b00;
              gap_cnt <= GAP_RELOAD;
            end
          end
        end

        GAP: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (gap_cnt == 4'd0) begin
            state  <= STEP;
            step_r <= 1'b1;
            m_r    <= mode_of(cmd_r);
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
          err_r  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // SI is combinational so rotates see the register value of the step cycle
  // itself; it is forced low whenever no step is being issued.
  always_comb begin
    si_c = 1'b0;
    if (state == STEP) begin
      case (cmd_r)
        CMD_SHR, CMD_SHL: si_c = si_r;
        CMD_ROR:          si_c = bus.q[0];
        CMD_ROL:          si_c = bus.q[3];
        default:          si_c = 1'b0;
      endcase
    end
  end

  assign bus.M       = m_r;
  assign bus.SI      = si_c;
  assign bus.D       = d_r;
  assign bus.step_en = step_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.err     = err_r;
  assign state_dbg   = state;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
`timescale 1ns/1ps
// tb_shift_reg_sequencer
// Drives command sequences into two sequencers (STEP_GAP=4 and STEP_GAP=1),
// each closed around a behavioural 4-bit universal shift register, and checks
// step timing, M/SI/D, status pulses and final register contents.
module tb_shift_reg_sequencer;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  logic [1:0] state_dbg1;

  always #5 clk = ~clk;

  shift_reg_sequencer_if sif ();
  shift_reg_sequencer_if sif1 ();

  shift_reg_sequencer #(.STEP_GAP(4)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (sif.slave),
    .state_dbg (state_dbg)
  );

  shift_reg_sequencer #(.STEP_GAP(1)) dut1 (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (sif1.slave),
    .state_dbg (state_dbg1)
  );

  // Behavioural universal shift registers fed by each sequencer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sif.q <= 4'd0;
    else if (sif.step_en) begin
      case (sif.M)
        2'b01:   sif.q <= {sif.SI, sif.q[3:1]};
        2'b10:   sif.q <= {sif.q[2:0], sif.SI};
        2'b11:   sif.q <= sif.D;
        default: sif.q <= sif.q;
      endcase
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sif1.q <= 4'd0;
    else if (sif1.step_en) begin
      case (sif1.M)
        2'b01:   sif1.q <= {sif1.SI, sif1.q[3:1]};
        2'b10:   sif1.q <= {sif1.q[2:0], sif1.SI};
        2'b11:   sif1.q <= sif1.D;
        default: sif1.q <= sif1.q;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  // Entry: {cycle offset after acceptance [10:3], M [2:1], SI [0]}
  logic [10:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  localparam logic [2:0] LOAD = 3'b000, CLEAR = 3'b001, SHR = 3'b010,
                         SHL = 3'b011, ROR = 3'b100, ROL = 3'b101;

  // ---------------- drivers ----------------
  task automatic send(input logic [2:0] c, input logic [3:0] n,
                      input logic [3:0] d, input logic s);
    @(negedge clk);
    sif.start = 1'b1; sif.cmd = c; sif.count = n; sif.data_in = d; sif.si_in = s;
    @(posedge clk);
    #1 sif.start = 1'b0;
  endtask

  task automatic send1(input logic [2:0] c, input logic [3:0] n,
                       input logic [3:0] d, input logic s);
    @(negedge clk);
    sif1.start = 1'b1; sif1.cmd = c; sif1.count = n; sif1.data_in = d; sif1.si_in = s;
    @(posedge clk);
    #1 sif1.start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic seen;
    logic [12:0] obs;
    rst_n = 1'b0;
    #1;
    obs = {sif.M, sif.SI, sif.D, sif.step_en, sif.busy, sif.done, sif.err, state_dbg};
    total++;
    if (obs !== 13'd0) begin
      bad++; $display("FAIL reset_idle: got %b want %b", obs, 13'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    send(SHR, 4'd5, 4'b1010, 1'b1);
    @(negedge clk);
    total++;
    if ({sif.step_en, sif.busy, sif.M} !== 4'b1101) begin
      bad++; $display("FAIL reset_pre_step: got step/busy/M=%b want 1101",
                      {sif.step_en, sif.busy, sif.M});
    end
    rst_n = 1'b0;
    #1;
    obs = {sif.M, sif.SI, sif.D, sif.step_en, sif.busy, sif.done, sif.err, state_dbg};
    total++;
    if (obs !== 13'd0) begin
      bad++; $display("FAIL reset_mid: got %b want %b", obs, 13'd0);
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (sif.step_en || sif.busy || sif.done) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL reset_after: activity seen=%b want 0", seen);
    end
  endtask

  task automatic test_load_clear();
    logic [10:0] e;
    logic [3:0]  v;
    logic [2:0]  c;
    logic [2:0]  ef;
    for (int n = 0; n < 4; n++) begin
      c = (n == 3) ? CLEAR : LOAD;
      v = (n == 0) ? 4'b1011 : 4'($urandom_range(1, 15));
      send(c, 4'($urandom_range(0, 15)), v, 1'($urandom_range(0, 1)));
      if (c == CLEAR) v = 4'd0;
      exp_q.push_back({8'd1, 2'b11, 1'b0});
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        if (sif.step_en) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL load_step: step_en at t+%0d, none expected", k);
          end else begin
            e = exp_q.pop_front();
            if ({8'(k), sif.M, sif.SI, sif.D} !== {e, v}) begin
              bad++; $display("FAIL load_step: got t+%0d M=%b SI=%b D=%b want t+%0d M=%b SI=%b D=%b",
                              k, sif.M, sif.SI, sif.D, e[10:3], e[2:1], e[0], v);
            end
          end
        end
        ef = {k == 1, k == 2, 1'b0};
        total++;
        if ({sif.busy, sif.done, sif.err} !== ef) begin
          bad++; $display("FAIL load_flags t+%0d: got busy/done/err=%b want %b",
                          k, {sif.busy, sif.done, sif.err}, ef);
        end
      end
      total++;
      if (exp_q.size() != 0) begin
        bad++; $display("FAIL load_missed: %0d steps left want 0", exp_q.size());
        exp_q.delete();
      end
      total++;
      if (sif.q !== v) begin
        bad++; $display("FAIL load_q: got %b want %b", sif.q, v);
      end
    end
  endtask

  task automatic test_shr();
    logic [10:0] e;
    logic [2:0]  ef;
    send(SHR, 4'd3, 4'($urandom_range(0, 15)), 1'b1);
    for (int i = 0; i < 3; i++) exp_q.push_back({8'(1 + 4 * i), 2'b01, 1'b1});
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (sif.step_en) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL shr_step: step_en at t+%0d, none expected", k);
        end else begin
          e = exp_q.pop_front();
          if ({8'(k), sif.M, sif.SI} !== e) begin
            bad++; $display("FAIL shr_step: got t+%0d M=%b SI=%b want t+%0d M=%b SI=%b",
                            k, sif.M, sif.SI, e[10:3], e[2:1], e[0]);
          end
        end
      end
      ef = {k <= 9, k == 10, 1'b0};
      total++;
      if ({sif.busy, sif.done, sif.err} !== ef) begin
        bad++; $display("FAIL shr_flags t+%0d: got busy/done/err=%b want %b",
                        k, {sif.busy, sif.done, sif.err}, ef);
      end
      // A start while busy must be dropped.
      if (k == 3) begin
        sif.start = 1'b1; sif.cmd = LOAD; sif.data_in = 4'b1111;
      end
      if (k == 4) sif.start = 1'b0;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL shr_missed: %0d steps left want 0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if (sif.q !== 4'b1110) begin
      bad++; $display("FAIL shr_q: got %b want 1110", sif.q);
    end
  endtask

  task automatic test_rotate();
    logic [10:0] e;
    logic [2:0]  ef;
    logic [3:0]  rol_si;
    send(LOAD, 4'd0, 4'b1001, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (sif.q !== 4'b1001) begin
      bad++; $display("FAIL rot_preload: got %b want 1001", sif.q);
    end

    // ROL x4 from 1001: SI follows q[3] = 1,0,0,1 and returns to 1001.
    rol_si = 4'b1001;
    send(ROL, 4'd4, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(1 + 4 * i), 2'b10, rol_si[3 - i]});
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (sif.step_en) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rol_step: step_en at t+%0d, none expected", k);
        end else begin
          e = exp_q.pop_front();
          if ({8'(k), sif.M, sif.SI} !== e) begin
            bad++; $display("FAIL rol_step: got t+%0d M=%b SI=%b want t+%0d M=%b SI=%b",
                            k, sif.M, sif.SI, e[10:3], e[2:1], e[0]);
          end
        end
      end
      ef = {k <= 13, k == 14, 1'b0};
      total++;
      if ({sif.busy, sif.done, sif.err} !== ef) begin
        bad++; $display("FAIL rol_flags t+%0d: got busy/done/err=%b want %b",
                        k, {sif.busy, sif.done, sif.err}, ef);
      end
    end
    total++;
    if (exp_q.size() != 0 || sif.q !== 4'b1001) begin
      bad++; $display("FAIL rol_end: left=%0d q=%b want left=0 q=1001", exp_q.size(), sif.q);
      exp_q.delete();
    end

    // ROR x2 from 1001: SI follows q[0] = 1 then 0, ending at 0110.
    send(ROR, 4'd2, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    exp_q.push_back({8'd1, 2'b01, 1'b1});
    exp_q.push_back({8'd5, 2'b01, 1'b0});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (sif.step_en) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL ror_step: step_en at t+%0d, none expected", k);
        end else begin
          e = exp_q.pop_front();
          if ({8'(k), sif.M, sif.SI} !== e) begin
            bad++; $display("FAIL ror_step: got t+%0d M=%b SI=%b want t+%0d M=%b SI=%b",
                            k, sif.M, sif.SI, e[10:3], e[2:1], e[0]);
          end
        end
      end
      ef = {k <= 5, k == 6, 1'b0};
      total++;
      if ({sif.busy, sif.done, sif.err} !== ef) begin
        bad++; $display("FAIL ror_flags t+%0d: got busy/done/err=%b want %b",
                        k, {sif.busy, sif.done, sif.err}, ef);
      end
    end
    total++;
    if (exp_q.size() != 0 || sif.q !== 4'b0110) begin
      bad++; $display("FAIL ror_end: left=%0d q=%b want left=0 q=0110", exp_q.size(), sif.q);
      exp_q.delete();
    end
  endtask

  task automatic test_zero_illegal();
    logic [2:0] cmds[4];
    logic [3:0] cnts[4];
    logic       errs[4];
    logic [2:0] ef;
    cmds = '{SHL, 3'b111, 3'b110, ROR};
    cnts = '{4'd0, 4'd5, 4'd2, 4'd0};
    errs = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int n = 0; n < 4; n++) begin
      send(cmds[n], cnts[n], 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        ef = {1'b0, k == 1, (k == 1) && errs[n]};
        total++;
        if ({sif.step_en, sif.busy, sif.done, sif.err} !== {1'b0, ef}) begin
          bad++; $display("FAIL zero_illegal cmd=%b t+%0d: got step/busy/done/err=%b want %b",
                          cmds[n], k, {sif.step_en, sif.busy, sif.done, sif.err}, {1'b0, ef});
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [10:0] e;
    logic [2:0]  ef;
    send(SHL, 4'd6, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    exp_q.push_back({8'd1, 2'b10, 1'b0});
    exp_q.push_back({8'd5, 2'b10, 1'b0});
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (sif.step_en) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL abort_step: step_en at t+%0d, none expected", k);
        end else begin
          e = exp_q.pop_front();
          // SI depends on the random fill bit; check offset and mode only.
          if ({8'(k), sif.M} !== e[10:1]) begin
            bad++; $display("FAIL abort_step: got t+%0d M=%b want t+%0d M=%b",
                            k, sif.M, e[10:3], e[2:1]);
          end
        end
      end
      ef = {k <= 6, 1'b0, 1'b0};
      total++;
      if ({sif.busy, sif.done, sif.err} !== ef) begin
        bad++; $display("FAIL abort_flags t+%0d: got busy/done/err=%b want %b",
                        k, {sif.busy, sif.done, sif.err}, ef);
      end
      if (k == 7) begin
        total++;
        if (state_dbg !== 2'd0) begin
          bad++; $display("FAIL abort_idle: got state %0d want 0", state_dbg);
        end
      end
      // abort and start together while busy: abort wins, start is dropped.
      if (k == 6) begin
        sif.abort = 1'b1; sif.start = 1'b1; sif.cmd = LOAD;
      end
      if (k == 7) begin
        sif.abort = 1'b0; sif.start = 1'b0;
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL abort_missed: %0d steps left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    logic [2:0]  ef;
    logic [3:0]  n;
    logic        s;
    logic [3:0]  q_want;
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? 4'd3 : 4'd15;
      s = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      q_want = (r == 0) ? 4'b0111 : {4{s}};
      send1(SHL, n, 4'($urandom_range(0, 15)), s);
      for (int i = 1; i <= int'(n); i++) exp_q.push_back({8'(i), 2'b10, s});
      for (int k = 1; k <= int'(n) + 3; k++) begin
        @(negedge clk);
        if (sif1.step_en) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL b2b_step: step_en at t+%0d, none expected", k);
          end else begin
            e = exp_q.pop_front();
            if ({8'(k), sif1.M, sif1.SI} !== e) begin
              bad++; $display("FAIL b2b_step: got t+%0d M=%b SI=%b want t+%0d M=%b SI=%b",
                              k, sif1.M, sif1.SI, e[10:3], e[2:1], e[0]);
            end
          end
        end
        ef = {k <= int'(n), k == int'(n) + 1, 1'b0};
        total++;
        if ({sif1.busy, sif1.done, sif1.err} !== ef) begin
          bad++; $display("FAIL b2b_flags t+%0d: got busy/done/err=%b want %b",
                          k, {sif1.busy, sif1.done, sif1.err}, ef);
        end
      end
      total++;
      if (exp_q.size() != 0 || sif1.q !== q_want) begin
        bad++; $display("FAIL b2b_end: left=%0d q=%b want left=0 q=%b",
                        exp_q.size(), sif1.q, q_want);
        exp_q.delete();
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    sif.start = 1'b0; sif.cmd = 3'd0; sif.count = 4'd0; sif.data_in = 4'd0;
    sif.si_in = 1'b0; sif.abort = 1'b0;
    sif1.start = 1'b0; sif1.cmd = 3'd0; sif1.count = 4'd0; sif1.data_in = 4'd0;
    sif1.si_in = 1'b0; sif1.abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    test_reset();
    test_load_clear();
    test_shr();
    test_rotate();
    test_zero_illegal();
    test_abort();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_reg_sequencer.md
# shift_reg_sequencer

Command sequencer for the 4-bit universal shift register. It accepts one command per start pulse (load, clear, shift or rotate N places) and drives the register's mode, serial-in and parallel-data inputs. It issues one single-cycle step enable per operation, paced at a fixed interval. It sits between the debounced/one-shot user controls and the shift register, replacing direct switch control of M/SI.

## Interface
Parameters:
- STEP_GAP, 4: clock cycles between consecutive step enables; legal range 1–15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  command request; sampled on clk, acted on only in IDLE
- cmd  input  3  000 LOAD, 001 CLEAR, 010 SHR, 011 SHL, 100 ROR, 101 ROL; 110/111 illegal
- count  input  4  number of shift/rotate steps (0–15); ignored for LOAD/CLEAR
- data_in  input  4  parallel value for LOAD
- si_in  input  1  fill bit for SHR/SHL
- abort  input  1  terminates an active command
- q  input  4  current shift-register contents (feedback for rotates)
- M  output  2  register mode: 00 hold, 01 shift right (SI→Q[3]), 10 shift left (SI→Q[0]), 11 parallel load
- SI  output  1  serial input to register
- D  output  4  parallel data to register
- step_en  output  1  one-cycle register enable; register acts only when high
- busy  output  1  command in progress
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle illegal-command pulse, coincident with done

## Operation
- States: IDLE, STEP, GAP, DONE.
- IDLE with start=1: latch cmd, count, data_in, si_in, then go to STEP. start in any other state is ignored; nothing is queued.
- LOAD: one step with M=11, D=latched data_in.
- CLEAR: one step with M=11, D=0000.
- SHR/SHL: count steps with M=01/10 and SI=latched si_in.
- ROR: SI=q[0], M=01. ROL: SI=q[3], M=10. q is sampled combinationally during the step cycle.
- count=0 for shift/rotate: IDLE→DONE directly; no step_en.
- Illegal cmd: IDLE→DONE with err=1; no step_en.
- STEP: step_en=1 and the mode is driven; the remaining-step counter decrements.
  - Remaining steps = 0 → DONE.
  - Otherwise → GAP for STEP_GAP−1 cycles, then STEP.
  - STEP_GAP=1 skips GAP, giving back-to-back steps.
- DONE: done=1 for one cycle, then IDLE.
- abort=1 in STEP or GAP: → IDLE next edge, no done. A step_en already high in that cycle still completes.
- Outside step cycles: M=00, SI=0, step_en=0. D holds the last latched value.
- Remaining-step counter is 4 bits and is loaded with count at acceptance; it never wraps.

## Timing
- Reset (reset=0, asynchronous): state IDLE, M=00, SI=0, D=0000, step_en=0, busy=0, done=0, err=0, counters cleared. Applies immediately, including mid-command.
- Let start be sampled high at the edge ending cycle t.
  - Step k (k=0..N−1) is high in cycle t+1+k·STEP_GAP.
  - done is high in cycle t+2+(N−1)·STEP_GAP.
- LOAD/CLEAR: step_en in t+1, done in t+2.
- Zero-count and illegal commands: done (and err if illegal) in t+1.
- busy: high from t+1 through the last STEP/GAP cycle; low in DONE and IDLE.
- Earliest next accepted start: sampled high in the cycle after DONE.
- abort and start high in the same cycle while busy: abort wins and start is ignored.

## Test plan
- Reset: hold reset=0 mid-SHR with count=5 → all outputs at reset values within the same cycle; after release, step_en stays 0 and busy=0.
- LOAD, data_in=1011, STEP_GAP=4 → step_en with M=11, D=1011 in t+1; register model q=1011; done in t+2; busy high only in t+1.
- SHR, count=3, si_in=1, q starts 0000 → step_en at t+1, t+5, t+9 with M=01; q=1110; done t+10; start pulsed at t+3 ignored.
- ROL, count=4, q=1001 → SI sequence 1,0,0,1 across the four steps; final q=1001; done t+14.
- SHL count=0 → no step_en, done t+1, err=0. cmd=111 → no step_en, done=err=1 in t+1.
- SHL count=6, abort high at t+6 → steps at t+1, t+5 only; IDLE at t+7; no done pulse; busy low from t+7.
